// File: rtl/star_sensor_conditioner_if.sv
// ---------------------------------------------------------------------------
// star_sensor_conditioner_if
//   Groups the raw operator/limit-switch inputs and the conditioned
//   controller-facing outputs of star_sensor_conditioner.
//
//   Signalling: there is no valid/ready handshake on this bundle. Every
//   signal is a level. Raw inputs may change at any time, asynchronously
//   to the clock. Conditioned outputs are registered, change only on the
//   rising clock edge, and are meaningful on every cycle.
//
//   Modports
//     master : environment side (drives raw inputs, observes outputs)
//     slave  : conditioner side (observes raw inputs, drives outputs)
//
//   Signals
//     i_btn_press_raw     raw "press" button (hide star), active high
//     i_btn_pull_raw      raw "pull" button (show star), active high
//     i_grill_closed_raw  grill closed limit switch, active high
//     i_grill_open_raw    grill open limit switch, active high
//     i_star_up_raw       star extended limit switch, active high
//     i_star_down_raw     star hidden limit switch, active high
//     o_press             debounced, qualified press level
//     o_pull              debounced, qualified pull level
//     o_grill_pos [1:0]   00 home, 01 end, 10 between, 11 invalid
//     o_star_pos  [1:0]   00 home, 01 end, 10 between, 11 invalid
//     o_fault             both limits of one axis asserted
// ---------------------------------------------------------------------------
interface star_sensor_conditioner_if;
    logic       i_btn_press_raw;
    logic       i_btn_pull_raw;
    logic       i_grill_closed_raw;
    logic       i_grill_open_raw;
    logic       i_star_up_raw;
    logic       i_star_down_raw;
    logic       o_press;
    logic       o_pull;
    logic [1:0] o_grill_pos;
    logic [1:0] o_star_pos;
    logic       o_fault;

    modport master (
        output i_btn_press_raw, i_btn_pull_raw,
        output i_grill_closed_raw, i_grill_open_raw,
        output i_star_up_raw, i_star_down_raw,
        input  o_press, o_pull, o_grill_pos, o_star_pos, o_fault
    );

    modport slave (
        input  i_btn_press_raw, i_btn_pull_raw,
        input  i_grill_closed_raw, i_grill_open_raw,
        input  i_star_up_raw, i_star_down_raw,
        output o_press, o_pull, o_grill_pos, o_star_pos, o_fault
    );
endinterface

// File: rtl/star_sensor_conditioner.sv
// ---------------------------------------------------------------------------
// star_sensor_conditioner
//   Input stage of the star-hiding controller. Each of the six raw inputs
//   (two buttons, four limit switches) is synchronised and debounced. The
//   debounced levels are then qualified (buttons) or encoded (limit-switch
//   pairs -> 2-bit position) and registered. The outputs are held at their
//   reset values until a startup counter has covered one full debounce
//   latency, so the controller never sees half-settled data.
//
//   Parameters
//     DEBOUNCE_CYCLES  stable synchronised samples needed to flip a debounced
//                      bit (>= 2)
//     FAULT_STICKY     1: o_fault latches until reset
//                      0: o_fault follows the live fault condition
//
//   Ports
//     i_clk    system clock, rising edge
//     i_rst_n  asynchronous active-low reset
//     bus      star_sensor_conditioner_if.slave (raw inputs / outputs)
// ---------------------------------------------------------------------------
module star_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter bit FAULT_STICKY    = 1'b1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    star_sensor_conditioner_if.slave    bus
);

    localparam int NUM_CH = 6;
    // Channel indices into the raw/debounced vectors.
    localparam int CH_PRESS        = 0;
    localparam int CH_PULL         = 1;
    localparam int CH_GRILL_CLOSED = 2;
    localparam int CH_GRILL_OPEN   = 3;
    localparam int CH_STAR_UP      = 4;
    localparam int CH_STAR_DOWN    = 5;

    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Startup covers sync (2) + debounce + output stage so the first value
    // released to the controller is already fully debounced.
    localparam int             SU_CYCLES = DEBOUNCE_CYCLES + 3;
    localparam int             SW        = $clog2(SU_CYCLES + 1);
    localparam logic [SW-1:0]  SU_LAST   = SW'(SU_CYCLES);

    logic [NUM_CH-1:0] raw;
    logic [NUM_CH-1:0] deb;

    assign raw[CH_PRESS]        = bus.i_btn_press_raw;
    assign raw[CH_PULL]         = bus.i_btn_pull_raw;
    assign raw[CH_GRILL_CLOSED] = bus.i_grill_closed_raw;
    assign raw[CH_GRILL_OPEN]   = bus.i_grill_open_raw;
    assign raw[CH_STAR_UP]      = bus.i_star_up_raw;
    assign raw[CH_STAR_DOWN]    = bus.i_star_down_raw;

    // ------------------------------------------------------------------
    // Per-channel synchroniser + debounce. The counter only advances while
    // the synchronised level disagrees with the debounced level; any sample
    // that agrees again restarts the count, so a bounce shorter than
    // DEBOUNCE_CYCLES samples never flips the debounced bit.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic          sync1;
        logic          sync2;
        logic          deb_q;
        logic [CW-1:0] cnt;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                sync1 <= 1'b0;
                sync2 <= 1'b0;
                deb_q <= 1'b0;
                cnt   <= '0;
            end else begin
                sync1 <= raw[i];
                sync2 <= sync1;
                if (sync2 == deb_q) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    deb_q <= sync2;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

        assign deb[i] = deb_q;
    end

    // ------------------------------------------------------------------
    // Startup counter: saturates at SU_CYCLES and only reruns after reset.
    // ------------------------------------------------------------------
    logic [SW-1:0] su_cnt;
    logic          su_done;

    assign su_done = (su_cnt == SU_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            su_cnt <= '0;
        end else if (!su_done) begin
            su_cnt <= su_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Encoding / qualification
    // ------------------------------------------------------------------
    function automatic logic [1:0] encode_axis(input logic home_lim, input logic end_lim);
        logic [1:0] code;
        case ({home_lim, end_lim})
            2'b10:   code = 2'b00;   // at home limit
            2'b01:   code = 2'b01;   // at end limit
            2'b00:   code = 2'b10;   // travelling between limits
            default: code = 2'b11;   // both limits: impossible, flag fault
        endcase
        return code;
    endfunction

    logic [1:0] grill_enc;
    logic [1:0] star_enc;
    logic       press_c;
    logic       pull_c;
    logic       fault_cond;

    always_comb begin
        grill_enc  = encode_axis(deb[CH_GRILL_CLOSED], deb[CH_GRILL_OPEN]);
        star_enc   = encode_axis(deb[CH_STAR_UP], deb[CH_STAR_DOWN]);
        // Conflicting buttons cancel out so press and pull are exclusive.
        press_c    = deb[CH_PRESS] & ~deb[CH_PULL];
        pull_c     = deb[CH_PULL] & ~deb[CH_PRESS];
        fault_cond = (grill_enc == 2'b11) | (star_enc == 2'b11);
    end

    // ------------------------------------------------------------------
    // Output register stage, held at reset values until startup expires.
    // ------------------------------------------------------------------
    logic       press_q;
    logic       pull_q;
    logic [1:0] grill_q;
    logic [1:0] star_q;
    logic       fault_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            press_q <= 1'b0;
            pull_q  <= 1'b0;
            grill_q <= 2'b11;
            star_q  <= 2'b11;
            fault_q <= 1'b0;
        end else if (su_done) begin
            press_q <= press_c;
            pull_q  <= pull_c;
            grill_q <= grill_enc;
            star_q  <= star_enc;
            fault_q <= FAULT_STICKY ? (fault_q | fault_cond) : fault_cond;
        end
    end

    assign bus.o_press     = press_q;
    assign bus.o_pull      = pull_q;
    assign bus.o_grill_pos = grill_q;
    assign bus.o_star_pos  = star_q;
    assign bus.o_fault     = fault_q;

endmodule

// File: tb/tb_star_sensor_conditioner.sv
// Bench for star_sensor_conditioner. Two instances share the same raw
// inputs: one with a sticky fault output, one with a live fault output.
// Expected output vectors are queued per cycle by the stimulus and a
// monitor compares them 1 ns after every rising edge.
//
// Vector layout: [7] press [6] pull [5:4] grill_pos [3:2] star_pos
//                [1] fault (sticky DUT) [0] fault (live DUT)
module tb_star_sensor_conditioner;

    localparam int D = 16;
    localparam int L = D + 3;   // raw-to-output latency in cycles

    localparam logic [7:0] V_RST     = 8'b0_0_11_11_0_0;
    localparam logic [7:0] V_HOME    = 8'b0_0_00_00_0_0;
    localparam logic [7:0] V_PULL    = 8'b0_1_00_00_0_0;
    localparam logic [7:0] V_BETW    = 8'b0_0_10_00_0_0;
    localparam logic [7:0] V_OPEN    = 8'b0_0_01_00_0_0;
    localparam logic [7:0] V_PRESS   = 8'b1_0_01_00_0_0;
    localparam logic [7:0] V_SFAULT  = 8'b0_0_01_11_1_1;
    localparam logic [7:0] V_SCLEAR  = 8'b0_0_01_00_1_0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // raw[5:0] = {star_down, star_up, grill_open, grill_closed, pull, press}
    logic [5:0] raw = 6'b0;

    star_sensor_conditioner_if s_if ();
    star_sensor_conditioner_if n_if ();

    assign s_if.i_btn_press_raw    = raw[0];
    assign s_if.i_btn_pull_raw     = raw[1];
    assign s_if.i_grill_closed_raw = raw[2];
    assign s_if.i_grill_open_raw   = raw[3];
    assign s_if.i_star_up_raw      = raw[4];
    assign s_if.i_star_down_raw    = raw[5];
    assign n_if.i_btn_press_raw    = raw[0];
    assign n_if.i_btn_pull_raw     = raw[1];
    assign n_if.i_grill_closed_raw = raw[2];
    assign n_if.i_grill_open_raw   = raw[3];
    assign n_if.i_star_up_raw      = raw[4];
    assign n_if.i_star_down_raw    = raw[5];

    star_sensor_conditioner #(.DEBOUNCE_CYCLES(D), .FAULT_STICKY(1'b1)) u_sticky (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (s_if.slave)
    );

    star_sensor_conditioner #(.DEBOUNCE_CYCLES(D), .FAULT_STICKY(1'b0)) u_live (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (n_if.slave)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    string      tag_q[$];
    int         cyc   = 0;
    int         total = 0;
    int         bad   = 0;

    function automatic logic [7:0] act_vec();
        return {s_if.o_press, s_if.o_pull, s_if.o_grill_pos, s_if.o_star_pos,
                s_if.o_fault, n_if.o_fault};
    endfunction

    function automatic logic [7:0] act_live_pos();
        return {n_if.o_press, n_if.o_pull, n_if.o_grill_pos, n_if.o_star_pos, 2'b00};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    task automatic check_both(input string name, input logic [7:0] exp);
        check(name, act_vec(), exp);
        check({name, "_live"}, act_live_pos(), {exp[7:2], 2'b00});
    endtask

    // Monitor: compares every queued expectation at its cycle.
    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            #1;
            while (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
                int         c;
                logic [7:0] e;
                string      t;
                c = exp_cyc_q.pop_front();
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                if (c < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL %s missed cyc=%0d now=%0d want=%b", t, c, cyc, e);
                end else begin
                    check_both(t, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic expect_range(input int c0, input int c1, input logic [7:0] v,
                                input string tag);
        for (int c = c0; c <= c1; c++) begin
            exp_q.push_back(v);
            exp_cyc_q.push_back(c);
            tag_q.push_back(tag);
        end
    endtask

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p;
        int r;

        // 1: reset, then startup with grill closed / star up
        raw = 6'b01_0_1_0_0;   // star_up, grill_closed
        expect_range(1, 3, V_RST, "reset");
        goto(3);
        rst_n = 1'b1;
        r = cyc;
        expect_range(r + 1, r + L, V_RST, "startup_hold");
        expect_range(r + L + 1, r + L + 3, V_HOME, "startup_done");
        goto(r + L + 4);

        // 2: pull glitch of D-1 cycles is filtered, then held pull
        p = cyc;
        raw[1] = 1'b1;
        expect_range(p + 1, p + 40, V_HOME, "pull_glitch");
        goto(p + D - 1);
        raw[1] = 1'b0;
        goto(p + 41);
        p = cyc;
        raw[1] = 1'b1;
        expect_range(p + 1, p + L - 1, V_HOME, "pull_pre");
        expect_range(p + L, p + 58, V_PULL, "pull_on");
        expect_range(p + 59, p + 62, V_HOME, "pull_off");
        goto(p + 40);
        raw[1] = 1'b0;
        goto(p + 63);

        // 3: grill closed drops with bounce, then grill open
        p = cyc;
        raw[2] = 1'b0;
        expect_range(p + 1, p + 30, V_HOME, "bounce_home");
        expect_range(p + 31, p + 58, V_BETW, "bounce_between");
        expect_range(p + 59, p + 62, V_OPEN, "grill_open");
        for (int k = 0; k < 4; k++) begin
            goto(p + 2 + 3 * k);
            raw[2] = 1'b1;
            goto(p + 3 + 3 * k);
            raw[2] = 1'b0;
        end
        goto(p + 40);
        raw[3] = 1'b1;
        goto(p + 63);

        // 4: both buttons cancel; releasing pull yields press
        p = cyc;
        raw[1:0] = 2'b11;
        expect_range(p + 1, p + 48, V_OPEN, "both_buttons");
        expect_range(p + 49, p + 70, V_PRESS, "press_on");
        expect_range(p + 71, p + 74, V_OPEN, "press_off");
        goto(p + 30);
        raw[1] = 1'b0;
        goto(p + 52);
        raw[0] = 1'b0;
        goto(p + 75);

        // 5: star both limits -> fault; clear -> sticky holds, live clears
        p = cyc;
        raw[5] = 1'b1;
        expect_range(p + 1, p + L - 1, V_OPEN, "fault_pre");
        expect_range(p + L, p + 48, V_SFAULT, "fault_on");
        expect_range(p + 49, p + 55, V_SCLEAR, "fault_clear");
        goto(p + 30);
        raw[5] = 1'b0;
        goto(p + 56);

        // 6: reset mid-debounce, full startup repeats
        p = cyc;
        raw[0] = 1'b1;
        expect_range(p + 1, p + 8, V_SCLEAR, "pre_reset");
        goto(p + 8);
        rst_n = 1'b0;
        #1;
        check_both("reset_async", V_RST);
        expect_range(p + 9, p + 11, V_RST, "in_reset");
        goto(p + 11);
        rst_n = 1'b1;
        r = cyc;
        expect_range(r + 1, r + L, V_RST, "restart_hold");
        expect_range(r + L + 1, r + L + 4, V_PRESS, "restart_done");
        goto(r + L + 6);

        check("drain", 8'(exp_q.size()), 8'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
